// File: rtl/xm_mw_pipeline.sv
// xm_mw_pipeline
// EX/MEM and MEM/WB pipeline registers for the 16-bit core, together with the
// data-memory access sequencer. An instruction in EX/MEM that loads or stores
// raises mem_req and holds the upstream stages until the memory acknowledges
// the access or the wait budget runs out. A timeout sets a sticky error flag
// and retires the access with zero load data.
module xm_mw_pipeline #(
    parameter int DW      = 16,
    parameter int RW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] ex_rt,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic          flush,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_up,
    output logic [RW-1:0] xm_rd,
    output logic [RW-1:0] xm_rt,
    output logic          xm_regwrite,
    output logic          xm_memwrite,
    output logic [DW-1:0] xm_alu_result,
    output logic [RW-1:0] mw_rd,
    output logic          mw_regwrite,
    output logic [DW-1:0] mw_wb_data,
    output logic          mem_err
);

    // The wait counter is 4 bits; TIMEOUT must fit in it.
    localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Sequencer state
    state_e        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          flush_pend_q, flush_pend_d;

    // EX/MEM register
    logic          xm_valid_q, xm_valid_d;
    logic [DW-1:0] xm_alu_result_q, xm_alu_result_d;
    logic [DW-1:0] xm_store_data_q, xm_store_data_d;
    logic [RW-1:0] xm_rd_q, xm_rd_d;
    logic [RW-1:0] xm_rt_q, xm_rt_d;
    logic          xm_regwrite_q, xm_regwrite_d;
    logic          xm_memread_q, xm_memread_d;
    logic          xm_memwrite_q, xm_memwrite_d;

    // MEM/WB register
    logic          mw_valid_q, mw_valid_d;
    logic [RW-1:0] mw_rd_q, mw_rd_d;
    logic          mw_regwrite_q, mw_regwrite_d;
    logic [DW-1:0] mw_wb_data_q, mw_wb_data_d;

    // Control decode
    logic          xm_mem_op_s;
    logic          at_limit_s;
    logic          timeout_s;
    logic          advance_s;
    logic          mem_req_s;
    logic          mem_we_s;
    logic          stall_up_s;

    // Decode whether EX/MEM owns a memory access and whether the pipe may move.
    always_comb begin
        xm_mem_op_s = xm_valid_q & (xm_memread_q | xm_memwrite_q);
        at_limit_s  = (state_q == ST_ACCESS) && (wait_cnt_q == TIMEOUT_C);
        timeout_s   = xm_mem_op_s & ~mem_ack & at_limit_s;
        // A non-memory instruction always moves; a memory op moves on ack or on
        // exhausting its wait budget. mem_ack with no request has no effect
        // because advancing is already unconditional in that case.
        advance_s   = ~xm_mem_op_s | mem_ack | at_limit_s;
    end

    // Sequencer state register; reset drops any outstanding access at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            mem_err_q    <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_err_q    <= mem_err_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Sequencer next state: count wait cycles and detect timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_IDLE: begin
                if (xm_mem_op_s && !mem_ack) begin
                    state_d    = ST_ACCESS;
                    wait_cnt_d = 4'd1;
                end else begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                end else if (at_limit_s) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                    mem_err_d  = 1'b1;
                end else begin
                    state_d    = ST_ACCESS;
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // Sequencer outputs: request, direction and upstream stall.
    always_comb begin
        mem_req_s  = xm_mem_op_s;
        mem_we_s   = xm_mem_op_s & xm_memwrite_q;
        stall_up_s = mem_req_s & ~mem_ack & ~at_limit_s;
    end

    // Pipeline register next values: load on advance, otherwise hold both stages.
    always_comb begin
        xm_valid_d      = xm_valid_q;
        xm_alu_result_d = xm_alu_result_q;
        xm_store_data_d = xm_store_data_q;
        xm_rd_d         = xm_rd_q;
        xm_rt_d         = xm_rt_q;
        xm_regwrite_d   = xm_regwrite_q;
        xm_memread_d    = xm_memread_q;
        xm_memwrite_d   = xm_memwrite_q;
        mw_valid_d      = mw_valid_q;
        mw_rd_d         = mw_rd_q;
        mw_regwrite_d   = mw_regwrite_q;
        mw_wb_data_d    = mw_wb_data_q;
        flush_pend_d    = flush_pend_q;
        if (advance_s) begin
            mw_valid_d    = xm_valid_q;
            mw_rd_d       = xm_rd_q;
            mw_regwrite_d = xm_regwrite_q;
            if (xm_memread_q) begin
                // A timed-out load retires with zero rather than bus garbage.
                if (timeout_s) begin
                    mw_wb_data_d = {DW{1'b0}};
                end else begin
                    mw_wb_data_d = mem_rdata;
                end
            end else begin
                mw_wb_data_d = xm_alu_result_q;
            end
            // A flush seen during the stall squashes the instruction now entering.
            xm_valid_d      = ex_valid & ~flush & ~flush_pend_q;
            xm_alu_result_d = ex_alu_result;
            xm_store_data_d = ex_store_data;
            xm_rd_d         = ex_rd;
            xm_rt_d         = ex_rt;
            xm_regwrite_d   = ex_regwrite;
            xm_memread_d    = ex_memread;
            xm_memwrite_d   = ex_memwrite;
            flush_pend_d    = 1'b0;
        end else begin
            // Stalled: remember any flush so it reaches the held EX instruction.
            flush_pend_d = flush_pend_q | flush;
        end
    end

    // EX/MEM and MEM/WB registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xm_valid_q      <= 1'b0;
            xm_alu_result_q <= {DW{1'b0}};
            xm_store_data_q <= {DW{1'b0}};
            xm_rd_q         <= {RW{1'b0}};
            xm_rt_q         <= {RW{1'b0}};
            xm_regwrite_q   <= 1'b0;
            xm_memread_q    <= 1'b0;
            xm_memwrite_q   <= 1'b0;
            mw_valid_q      <= 1'b0;
            mw_rd_q         <= {RW{1'b0}};
            mw_regwrite_q   <= 1'b0;
            mw_wb_data_q    <= {DW{1'b0}};
        end else begin
            xm_valid_q      <= xm_valid_d;
            xm_alu_result_q <= xm_alu_result_d;
            xm_store_data_q <= xm_store_data_d;
            xm_rd_q         <= xm_rd_d;
            xm_rt_q         <= xm_rt_d;
            xm_regwrite_q   <= xm_regwrite_d;
            xm_memread_q    <= xm_memread_d;
            xm_memwrite_q   <= xm_memwrite_d;
            mw_valid_q      <= mw_valid_d;
            mw_rd_q         <= mw_rd_d;
            mw_regwrite_q   <= mw_regwrite_d;
            mw_wb_data_q    <= mw_wb_data_d;
        end
    end

    // Output mapping; write enables are qualified so R0 is never written.
    always_comb begin
        mem_req       = mem_req_s;
        mem_we        = mem_we_s;
        mem_addr      = xm_alu_result_q;
        mem_wdata     = xm_store_data_q;
        stall_up      = stall_up_s;
        xm_rd         = xm_rd_q;
        xm_rt         = xm_rt_q;
        xm_regwrite   = xm_valid_q & xm_regwrite_q & (xm_rd_q != {RW{1'b0}});
        xm_memwrite   = xm_valid_q & xm_memwrite_q;
        xm_alu_result = xm_alu_result_q;
        mw_rd         = mw_rd_q;
        mw_regwrite   = mw_valid_q & mw_regwrite_q & (mw_rd_q != {RW{1'b0}});
        mw_wb_data    = mw_wb_data_q;
        mem_err       = mem_err_q;
    end

endmodule

// File: tb/tb_xm_mw_pipeline.sv
// Bench for xm_mw_pipeline: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// model of the two pipeline slots and the outstanding access.
module tb_xm_mw_pipeline;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic [15:0] ex_alu_result = 16'h0000;
    logic [15:0] ex_store_data = 16'h0000;
    logic [3:0]  ex_rd = 4'h0;
    logic [3:0]  ex_rt = 4'h0;
    logic        ex_regwrite = 1'b0;
    logic        ex_memread = 1'b0;
    logic        ex_memwrite = 1'b0;
    logic        flush = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_req, mem_we, stall_up, xm_regwrite, xm_memwrite, mw_regwrite, mem_err;
    logic [15:0] mem_addr, mem_wdata, xm_alu_result, mw_wb_data;
    logic [3:0]  xm_rd, xm_rt, mw_rd;

    int errors = 0;
    int checks = 0;

    xm_mw_pipeline #(.DW(16), .RW(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_up(stall_up),
        .xm_rd(xm_rd), .xm_rt(xm_rt), .xm_regwrite(xm_regwrite), .xm_memwrite(xm_memwrite),
        .xm_alu_result(xm_alu_result), .mw_rd(mw_rd), .mw_regwrite(mw_regwrite),
        .mw_wb_data(mw_wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction sitting in each slot, how long the
    // current memory access has waited, a pending flush and the error flag.
    logic        m_xv, m_xrw, m_xmr, m_xmw;
    logic [15:0] m_xalu, m_xsd;
    logic [3:0]  m_xrd, m_xrt;
    logic        m_wv, m_wrw;
    logic [3:0]  m_wrd;
    logic [15:0] m_wdata;
    int          m_age;
    logic        m_fp, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_xv = 1'b0; m_xrw = 1'b0; m_xmr = 1'b0; m_xmw = 1'b0;
        m_xalu = 16'h0; m_xsd = 16'h0; m_xrd = 4'h0; m_xrt = 4'h0;
        m_wv = 1'b0; m_wrw = 1'b0; m_wrd = 4'h0; m_wdata = 16'h0;
        m_age = 0; m_fp = 1'b0; m_err = 1'b0;
    endtask

    function automatic logic m_memop();
        return m_xv && (m_xmr || m_xmw);
    endfunction

    function automatic logic m_timed_out();
        return m_memop() && !mem_ack && (m_age == TMO);
    endfunction

    function automatic logic m_stall();
        return m_memop() && !mem_ack && (m_age != TMO);
    endfunction

    // Compare every DUT output with what the model says this cycle.
    task automatic compare();
        logic e_req;
        e_req = m_memop();
        chk("mem_req", mem_req, e_req);
        if (e_req) begin
            chk("mem_we", mem_we, m_xmw);
            chk("mem_addr", mem_addr, m_xalu);
            chk("mem_wdata", mem_wdata, m_xsd);
        end
        chk("stall_up", stall_up, m_stall());
        chk("xm_rd", xm_rd, m_xrd);
        chk("xm_rt", xm_rt, m_xrt);
        chk("xm_regwrite", xm_regwrite, m_xv && m_xrw && (m_xrd != 4'h0));
        chk("xm_memwrite", xm_memwrite, m_xv && m_xmw);
        chk("xm_alu_result", xm_alu_result, m_xalu);
        chk("mw_rd", mw_rd, m_wrd);
        chk("mw_regwrite", mw_regwrite, m_wv && m_wrw && (m_wrd != 4'h0));
        chk("mw_wb_data", mw_wb_data, m_wdata);
        chk("mem_err", mem_err, m_err);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        logic to;
        if (!rst) begin
            model_reset();
        end else begin
            to = m_timed_out();
            if (m_stall()) begin
                m_age = m_age + 1;
                m_fp  = m_fp | flush;
            end else begin
                m_wv    = m_xv;
                m_wrd   = m_xrd;
                m_wrw   = m_xrw;
                m_wdata = m_xmr ? (to ? 16'h0000 : mem_rdata) : m_xalu;
                m_err   = m_err | to;
                m_xv    = ex_valid && !flush && !m_fp;
                m_xalu  = ex_alu_result; m_xsd = ex_store_data;
                m_xrd   = ex_rd; m_xrt = ex_rt;
                m_xrw   = ex_regwrite; m_xmr = ex_memread; m_xmw = ex_memwrite;
                m_fp    = 1'b0;
                m_age   = 0;
            end
        end
    endtask

    // Inputs are applied at a falling edge; check, step the model, go to the next falling edge.
    task automatic step();
        #1;
        if (!rst) model_reset();
        compare();
        model_update();
        @(negedge clk);
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_alu_result = 16'h0; ex_store_data = 16'h0;
        ex_rd = 4'h0; ex_rt = 4'h0; ex_regwrite = 1'b0;
        ex_memread = 1'b0; ex_memwrite = 1'b0; flush = 1'b0;
    endtask

    task automatic ex_set(input logic [15:0] alu, input logic [3:0] rd, input logic rw,
                          input logic mr, input logic mw, input logic [15:0] sd, input logic [3:0] rt);
        ex_valid = 1'b1; ex_alu_result = alu; ex_rd = rd; ex_regwrite = rw;
        ex_memread = mr; ex_memwrite = mw; ex_store_data = sd; ex_rt = rt; flush = 1'b0;
    endtask

    int pcts[4] = '{100, 40, 10, 0};
    int ack_pct;
    int op;

    initial begin
        model_reset();
        // Reset: everything reads zero while rst is low.
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_stall_up", stall_up, 1'b0);
        chk("rst_mw_wb_data", mw_wb_data, 16'h0);
        chk("rst_mem_err", mem_err, 1'b0);
        @(negedge clk);
        step();
        rst = 1'b1;
        step();

        // 1: ALU op to r3 flows through XM then MW.
        ex_set(16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
        step();
        ex_idle();
        #1;
        chk("t1_xm_rd", xm_rd, 4'd3);
        chk("t1_xm_regwrite", xm_regwrite, 1'b1);
        step();
        #1;
        chk("t1_mw_rd", mw_rd, 4'd3);
        chk("t1_mw_regwrite", mw_regwrite, 1'b1);
        chk("t1_mw_wb_data", mw_wb_data, 16'h1234);
        step();

        // 2: ALU r2 then a load to r5 acked after three wait cycles.
        ex_set(16'h0022, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
        step();
        ex_set(16'h0040, 4'd5, 1'b1, 1'b1, 1'b0, 16'h0, 4'd0);
        step();
        ex_set(16'h0066, 4'd6, 1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_up", stall_up, 1'b1);
            chk("t2_mem_req", mem_req, 1'b1);
            chk("t2_mem_we", mem_we, 1'b0);
            chk("t2_mem_addr", mem_addr, 16'h0040);
            chk("t2_xm_rd_hold", xm_rd, 4'd5);
            chk("t2_mw_rd_hold", mw_rd, 4'd2);
            chk("t2_mw_data_hold", mw_wb_data, 16'h0022);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("t2_ack_stall", stall_up, 1'b0);
        step();
        ex_idle(); mem_ack = 1'b0; mem_rdata = 16'h0;
        #1;
        chk("t2_mw_wb_data", mw_wb_data, 16'hBEEF);
        chk("t2_mw_rd", mw_rd, 4'd5);
        chk("t2_mw_regwrite", mw_regwrite, 1'b1);
        chk("t2_xm_rd", xm_rd, 4'd6);
        step();

        // 3: zero-wait store.
        ex_set(16'h0100, 4'd0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 4'd7);
        step();
        ex_idle(); mem_ack = 1'b1;
        #1;
        chk("t3_mem_req", mem_req, 1'b1);
        chk("t3_mem_we", mem_we, 1'b1);
        chk("t3_mem_addr", mem_addr, 16'h0100);
        chk("t3_mem_wdata", mem_wdata, 16'hCAFE);
        chk("t3_stall_up", stall_up, 1'b0);
        chk("t3_xm_memwrite", xm_memwrite, 1'b1);
        step();
        mem_ack = 1'b0;
        step();

        // 4: flush pulsed while a load stalls; load still writes back.
        ex_set(16'h0200, 4'd9, 1'b1, 1'b1, 1'b0, 16'h0, 4'd0);
        step();
        ex_set(16'h00AA, 4'd10, 1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
        flush = 1'b1;
        #1;
        chk("t4_stall_up", stall_up, 1'b1);
        step();
        flush = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        ex_idle(); mem_ack = 1'b0; mem_rdata = 16'h0;
        #1;
        chk("t4_xm_regwrite", xm_regwrite, 1'b0);
        chk("t4_mw_rd", mw_rd, 4'd9);
        chk("t4_mw_regwrite", mw_regwrite, 1'b1);
        chk("t4_mw_wb_data", mw_wb_data, 16'h1111);
        step();

        // 5: writes to R0 are never enabled.
        ex_set(16'h5555, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
        step();
        ex_idle();
        #1;
        chk("t5_xm_regwrite", xm_regwrite, 1'b0);
        step();
        #1;
        chk("t5_mw_regwrite", mw_regwrite, 1'b0);
        chk("t5_mw_wb_data", mw_wb_data, 16'h5555);
        step();

        // 6: timeout with garbage on the bus, then reset in the middle of an access.
        ex_set(16'h0300, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0, 4'd0);
        step();
        ex_idle(); mem_rdata = 16'hDEAD;
        for (int i = 0; i < TMO; i++) begin
            #1;
            chk("t6_stall_up", stall_up, 1'b1);
            step();
        end
        #1;
        chk("t6_limit_stall", stall_up, 1'b0);
        chk("t6_limit_req", mem_req, 1'b1);
        chk("t6_err_before", mem_err, 1'b0);
        step();
        #1;
        chk("t6_mem_err", mem_err, 1'b1);
        chk("t6_mw_rd", mw_rd, 4'd4);
        chk("t6_mw_wb_data", mw_wb_data, 16'h0000);
        chk("t6_stall_after", stall_up, 1'b0);
        step();
        ex_set(16'h0400, 4'd7, 1'b1, 1'b1, 1'b0, 16'h0, 4'd0);
        step();
        ex_idle();
        step();
        step();
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_mem_req", mem_req, 1'b0);
        chk("t6_rst_stall", stall_up, 1'b0);
        chk("t6_rst_mem_err", mem_err, 1'b0);
        chk("t6_rst_addr", mem_addr, 16'h0);
        chk("t6_rst_mw_data", mw_wb_data, 16'h0);
        chk("t6_rst_mw_rd", mw_rd, 4'h0);
        step();
        rst = 1'b1; mem_rdata = 16'h0;
        step();

        // Randomized traffic with varying memory responsiveness and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) ack_pct = pcts[(c / 500) % 4];
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
            op            = int'($urandom_range(0, 3));
            ex_valid      = ($urandom_range(0, 9) < 8);
            ex_memread    = (op == 2);
            ex_memwrite   = (op == 3);
            ex_regwrite   = (op == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            ex_rd         = 4'($urandom);
            ex_rt         = 4'($urandom);
            ex_alu_result = 16'($urandom);
            ex_store_data = 16'($urandom);
            flush         = ($urandom_range(0, 9) == 0);
            mem_ack       = (int'($urandom_range(0, 99)) < ack_pct);
            mem_rdata     = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
